data_mem_responder: RTL and testbench

- Responder end of the core's load/store data-memory interface; the core or its LSU is the initiator.
- Accepts one request at a time over a valid/ready request channel.
- Models a configurable access latency and byte-addressed little-endian 64-bit storage.
- Returns read data, or write completion, over a valid/ready response channel; replaces the zero-latency data memory when the core is moved to stalling memory.

---
 rtl/data_mem_responder.sv | 163 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: one outstanding load/store at a time, fixed access
// latency, byte-addressed little-endian storage behind valid/ready channels.
module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 64,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [63:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned NBYTES = DEPTH_WORDS * 8;
   localparam int unsigned AW     = $clog2(NBYTES);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        wr_q, wr_d;
   logic [63:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic [63:0] wdata_q, wdata_d;
   logic [63:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [7:0]  mem_q [NBYTES];

   logic        acc_go;
   logic        acc_wr;
   logic [63:0] acc_addr;
   logic [1:0]  acc_size;
   logic [63:0] acc_wdata;
   logic [3:0]  acc_nb;
   logic [AW-1:0] acc_idx;
   logic        acc_mis;
   logic [64:0] acc_end;
   logic        acc_err;
   logic [63:0] acc_rdata;

   // With LATENCY=1 the access happens on the accepting edge, straight
   // from the request inputs; otherwise from the latched copy.
   always_comb begin
      acc_wr    = wr_q;
      acc_addr  = addr_q;
      acc_size  = size_q;
      acc_wdata = wdata_q;
      if (state_q == IDLE) begin
         acc_wr    = req_write;
         acc_addr  = req_addr;
         acc_size  = req_size;
         acc_wdata = req_wdata;
      end
      acc_nb  = 4'd1 << acc_size;
      acc_idx = acc_addr[AW-1:0];
      unique case (acc_size)
         2'd0:    acc_mis = 1'b0;
         2'd1:    acc_mis = acc_addr[0];
         2'd2:    acc_mis = |acc_addr[1:0];
         default: acc_mis = |acc_addr[2:0];
      endcase
      acc_end = {1'b0, acc_addr} + 65'(acc_nb);
      acc_err = acc_mis || (acc_end > 65'(NBYTES));
      acc_rdata = '0;
      for (int i = 0; i < 8; i++) begin
         if (4'(i) < acc_nb)
            acc_rdata[8*i +: 8] = mem_q[acc_idx + AW'(i)];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      size_d  = size_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      acc_go  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               wr_d    = req_write;
               addr_d  = req_addr;
               size_d  = req_size;
               wdata_d = req_wdata;
               cnt_d   = 4'(LATENCY - 1);
               if (LATENCY == 1) begin
                  acc_go  = 1'b1;
                  state_d = RESP;
               end else begin
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            if (cnt_q == 4'd1) begin
               acc_go  = 1'b1;
               cnt_d   = 4'd0;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
               rdata_d = '0;
               err_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      if (acc_go) begin
         err_d   = acc_err;
         rdata_d = (acc_err || acc_wr) ? 64'd0 : acc_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         size_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < int'(NBYTES); i++)
            mem_q[i] <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         if (acc_go && acc_wr && !acc_err) begin
            for (int i = 0; i < 8; i++) begin
               if (4'(i) < acc_nb)
                  mem_q[acc_idx + AW'(i)] <= acc_wdata[8*i +: 8];
            end
         end
      end
   end

   assign req_ready  = !reset && (state_q == IDLE);
   assign resp_valid = !reset && (state_q == RESP);
   assign resp_rdata = reset ? 64'd0 : rdata_q;
   assign resp_err   = !reset && err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed loads/stores on a
// LATENCY=2 instance plus latency probes on LATENCY=1 and LATENCY=15 builds.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_write;
   logic [63:0] req_addr, req_wdata;
   logic [1:0]  req_size;
   logic        resp_valid, resp_ready;
   logic [63:0] resp_rdata;
   logic        resp_err;

   logic        ax_valid [2];
   logic        ax_ready [2];
   logic        ax_rv    [2];
   logic [63:0] ax_rd    [2];
   logic        ax_err   [2];

   typedef struct {
      logic [63:0] rdata;
      logic        err;
   } exp_t;

   exp_t  exp_q[$];
   exp_t  mon_e;
   int    n_cmp = 0;
   int    n_bad = 0;
   int    cyc = 0;
   int    acc_cyc = 0;
   logic  prev_v = 1'b0;
   string tag = "reset";

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   data_mem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   data_mem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) dut_l1 (
      .clk(clk), .reset(reset),
      .req_valid(ax_valid[0]), .req_ready(ax_ready[0]), .req_write(1'b0),
      .req_addr(64'd0), .req_size(2'd3), .req_wdata(64'd0),
      .resp_valid(ax_rv[0]), .resp_ready(1'b1),
      .resp_rdata(ax_rd[0]), .resp_err(ax_err[0])
   );

   data_mem_responder #(.DEPTH_WORDS(64), .LATENCY(15)) dut_l15 (
      .clk(clk), .reset(reset),
      .req_valid(ax_valid[1]), .req_ready(ax_ready[1]), .req_write(1'b0),
      .req_addr(64'd0), .req_size(2'd3), .req_wdata(64'd0),
      .resp_valid(ax_rv[1]), .resp_ready(1'b1),
      .resp_rdata(ax_rd[1]), .resp_err(ax_err[1])
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s [%s]: got 0x%0h, expected 0x%0h", nm, tag, act, req);
      end
   endtask

   // Response monitor: pops the scoreboard on every response handshake
   always @(negedge clk) begin
      if (!reset) begin
         if (req_valid && req_ready) acc_cyc = cyc;
         if (resp_valid && !prev_v)
            chk("latency", 64'(cyc - acc_cyc), 64'd2);
         if (resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_resp", 64'd1, 64'd0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("rdata", resp_rdata, mon_e.rdata);
               chk("err", 64'(resp_err), 64'(mon_e.err));
            end
         end
      end
      prev_v = resp_valid;
   end

   task automatic send(input logic w, input logic [63:0] a,
                       input logic [1:0] s, input logic [63:0] wd,
                       input logic [63:0] er, input logic ee,
                       input bit push);
      bit ok = 1'b0;
      if (push) exp_q.push_back('{er, ee});
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_size  = s;
      req_wdata = wd;
      for (int n = 0; n < 100 && !ok; n++) begin
         @(negedge clk);
         ok = req_ready;
      end
      if (!ok) begin
         chk("accept_timeout", 64'd0, 64'd1);
         if (push) void'(exp_q.pop_back());
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_write = ~w;
      req_addr  = '1;
      req_size  = ~s;
      req_wdata = ~wd;
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 100 && exp_q.size() != 0; n++)
         @(negedge clk);
      if (exp_q.size() != 0) begin
         chk("resp_timeout", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   task automatic aux_lat(input int k, input int lat);
      bit ok = 1'b0;
      int a = 0;
      @(posedge clk); #1;
      ax_valid[k] = 1'b1;
      @(negedge clk);
      chk("aux_ready", 64'(ax_ready[k]), 64'd1);
      a = cyc;
      @(posedge clk); #1;
      ax_valid[k] = 1'b0;
      for (int n = 0; n < 40 && !ok; n++) begin
         @(negedge clk);
         if (ax_rv[k]) begin
            ok = 1'b1;
            chk("aux_latency", 64'(cyc - a), 64'(lat));
            chk("aux_rdata", ax_rd[k], 64'd0);
         end
      end
      if (!ok) chk("aux_resp_timeout", 64'd0, 64'd1);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] h_rd;
      logic        h_err;
      bit          ok;
      reset = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
      req_size = '0; req_wdata = '0; resp_ready = 1'b1;
      ax_valid[0] = 1'b0; ax_valid[1] = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_rdata", resp_rdata, 64'd0);
      chk("rst_err", 64'(resp_err), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("idle_req_ready", 64'(req_ready), 64'd1);

      tag = "st_dw_10";
      send(1, 64'h10, 2'd3, 64'h1122334455667788, 64'd0, 0, 1);
      @(negedge clk);
      chk("busy_req_ready", 64'(req_ready), 64'd0);
      wait_idle();
      tag = "ld_dw_10";
      send(0, 64'h10, 2'd3, 64'd0, 64'h1122334455667788, 0, 1); wait_idle();
      tag = "ld_b_10";
      send(0, 64'h10, 2'd0, 64'd0, 64'h88, 0, 1); wait_idle();
      tag = "ld_h_12";
      send(0, 64'h12, 2'd1, 64'd0, 64'h5566, 0, 1); wait_idle();
      tag = "ld_w_14";
      send(0, 64'h14, 2'd2, 64'd0, 64'h11223344, 0, 1); wait_idle();
      tag = "st_b_17";
      send(1, 64'h17, 2'd0, 64'hFFFF_FFFF_FFFF_FFAB, 64'd0, 0, 1); wait_idle();
      tag = "ld_dw_10b";
      send(0, 64'h10, 2'd3, 64'd0, 64'hAB22334455667788, 0, 1); wait_idle();

      tag = "ld_w_mis";
      send(0, 64'h12, 2'd2, 64'd0, 64'd0, 1, 1); wait_idle();
      tag = "st_dw_oor";
      send(1, 64'h200, 2'd3, 64'hDEADBEEFCAFEF00D, 64'd0, 1, 1); wait_idle();
      tag = "st_h_mis";
      send(1, 64'h11, 2'd1, 64'hFFFF, 64'd0, 1, 1); wait_idle();
      tag = "ld_hi_addr";
      send(0, 64'h8000_0000_0000_0010, 2'd3, 64'd0, 64'd0, 1, 1); wait_idle();
      tag = "ld_dw_10c";
      send(0, 64'h10, 2'd3, 64'd0, 64'hAB22334455667788, 0, 1); wait_idle();
      tag = "st_dw_1f8";
      send(1, 64'h1F8, 2'd3, 64'h0102030405060708, 64'd0, 0, 1); wait_idle();
      tag = "ld_dw_1f8";
      send(0, 64'h1F8, 2'd3, 64'd0, 64'h0102030405060708, 0, 1); wait_idle();
      tag = "ld_b_1ff";
      send(0, 64'h1FF, 2'd0, 64'd0, 64'h01, 0, 1); wait_idle();

      tag = "backpressure";
      resp_ready = 1'b0;
      send(0, 64'h10, 2'd3, 64'd0, 64'hAB22334455667788, 0, 1);
      ok = 1'b0;
      for (int n = 0; n < 20 && !ok; n++) begin
         @(negedge clk);
         ok = resp_valid;
      end
      h_rd  = resp_rdata;
      h_err = resp_err;
      exp_q.push_back('{64'hAB, 1'b0});
      req_valid = 1'b1; req_write = 1'b0;
      req_addr = 64'h17; req_size = 2'd0; req_wdata = 64'd0;
      repeat (5) begin
         @(negedge clk);
         chk("bp_valid", 64'(resp_valid), 64'd1);
         chk("bp_rdata", resp_rdata, h_rd);
         chk("bp_err", 64'(resp_err), 64'(h_err));
         chk("bp_req_ready", 64'(req_ready), 64'd0);
      end
      @(posedge clk); #1;
      resp_ready = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 10 && !ok; n++) begin
         @(negedge clk);
         ok = req_ready;
      end
      if (!ok) chk("bp_second_accept", 64'd0, 64'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      tag = "bp_second";
      wait_idle();

      tag = "lat1";
      aux_lat(0, 1);
      tag = "lat15";
      aux_lat(1, 15);

      tag = "rst_busy";
      send(1, 64'h0, 2'd0, 64'hFF, 64'd0, 0, 0);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_valid", 64'(resp_valid), 64'd0);
      chk("post_rst_ready", 64'(req_ready), 64'd1);
      tag = "ld_dw_0";
      send(0, 64'h0, 2'd3, 64'd0, 64'd0, 0, 1); wait_idle();
      tag = "ld_dw_10_clr";
      send(0, 64'h10, 2'd3, 64'd0, 64'd0, 0, 1); wait_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
